// File: rtl/return_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module   : return_tag_tracker
// Purpose  : Queues return tags of forwarded requests and stamps the matching
//            destination/VC onto the in-order responses sent back to the NoC.
// Revision : 1.0
// ============================================================================
module return_tag_tracker #(
    parameter int WIDTH_DATA       = 12,
    parameter int TAG_WIDTH        = 8,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int DEPTH            = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH_DATA-1:0]       dp_data_in,
    input  logic [TAG_WIDTH-1:0]        dp_tag_in,
    input  logic                        dp_valid_in,
    output logic                        dp_ready_out,
    output logic [WIDTH_DATA-1:0]       mod_data_out,
    output logic                        mod_valid_out,
    input  logic                        mod_ready_in,
    input  logic [WIDTH_DATA-1:0]       rsp_data_in,
    input  logic                        rsp_valid_in,
    output logic                        rsp_ready_out,
    output logic [WIDTH_DATA-1:0]       pk_data_out,
    output logic [ADDRESS_WIDTH-1:0]    pk_dest_out,
    output logic [VC_ADDRESS_WIDTH-1:0] pk_vc_out,
    output logic                        pk_valid_out,
    input  logic                        pk_ready_in,
    output logic [$clog2(DEPTH):0]      outstanding_out,
    output logic                        orphan_err_out
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_FIELD_W = ADDRESS_WIDTH + VC_ADDRESS_WIDTH;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    // Only the dest/VC field of a tag is ever returned, so only it is stored.
    logic [c_FIELD_W-1:0] r_tag_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_orphan;
    logic [WIDTH_DATA-1:0]       r_pk_data;
    logic [ADDRESS_WIDTH-1:0]    r_pk_dest;
    logic [VC_ADDRESS_WIDTH-1:0] r_pk_vc;
    logic                        r_pk_valid;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_load;
    logic [c_FIELD_W-1:0] w_head;
    logic                 w_unused_tag;

    assign w_unused_tag = ^dp_tag_in;

    // Full/empty come from the registered count only: no same-cycle bypass.
    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_head  = r_tag_mem[r_rd_ptr];

    assign mod_data_out  = dp_data_in;
    assign mod_valid_out = dp_valid_in & ~w_full;
    assign dp_ready_out  = mod_ready_in & ~w_full;
    assign w_push        = dp_valid_in & dp_ready_out;

    assign rsp_ready_out = ~w_empty & (~r_pk_valid | pk_ready_in);
    assign w_load        = rsp_valid_in & rsp_ready_out;

    assign pk_data_out     = r_pk_data;
    assign pk_dest_out     = r_pk_dest;
    assign pk_vc_out       = r_pk_vc;
    assign pk_valid_out    = r_pk_valid;
    assign outstanding_out = r_count;
    assign orphan_err_out  = r_orphan;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= dp_tag_in[c_FIELD_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_orphan   <= 1'b0;
            r_pk_data  <= '0;
            r_pk_dest  <= '0;
            r_pk_vc    <= '0;
            r_pk_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (rsp_valid_in & w_empty) begin
                r_orphan <= 1'b1;
            end

            // Output stage: load a new beat, or retire the held one once taken.
            if (w_load) begin
                r_pk_data  <= rsp_data_in;
                r_pk_dest  <= w_head[c_FIELD_W-1:VC_ADDRESS_WIDTH];
                r_pk_vc    <= w_head[VC_ADDRESS_WIDTH-1:0];
                r_pk_valid <= 1'b1;
            end else if (pk_ready_in) begin
                r_pk_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_return_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_return_tag_tracker
// Purpose  : Directed vector table plus hand sequences for return_tag_tracker.
// Revision : 1.0
// ============================================================================
module tb_return_tag_tracker;

    logic        clk;
    logic        rst;
    logic [11:0] dp_data_in;
    logic [7:0]  dp_tag_in;
    logic        dp_valid_in;
    logic        dp_ready_out;
    logic [11:0] mod_data_out;
    logic        mod_valid_out;
    logic        mod_ready_in;
    logic [11:0] rsp_data_in;
    logic        rsp_valid_in;
    logic        rsp_ready_out;
    logic [11:0] pk_data_out;
    logic [3:0]  pk_dest_out;
    logic [0:0]  pk_vc_out;
    logic        pk_valid_out;
    logic        pk_ready_in;
    logic [2:0]  outstanding_out;
    logic        orphan_err_out;

    int checks = 0;
    int errors = 0;

    return_tag_tracker dut (
        .clk             (clk),
        .rst             (rst),
        .dp_data_in      (dp_data_in),
        .dp_tag_in       (dp_tag_in),
        .dp_valid_in     (dp_valid_in),
        .dp_ready_out    (dp_ready_out),
        .mod_data_out    (mod_data_out),
        .mod_valid_out   (mod_valid_out),
        .mod_ready_in    (mod_ready_in),
        .rsp_data_in     (rsp_data_in),
        .rsp_valid_in    (rsp_valid_in),
        .rsp_ready_out   (rsp_ready_out),
        .pk_data_out     (pk_data_out),
        .pk_dest_out     (pk_dest_out),
        .pk_vc_out       (pk_vc_out),
        .pk_valid_out    (pk_valid_out),
        .pk_ready_in     (pk_ready_in),
        .outstanding_out (outstanding_out),
        .orphan_err_out  (orphan_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [7:0]  tag;
        logic [11:0] dd;
        logic        mr;
        logic        rv;
        logic [11:0] rd;
        logic        pr;
        logic        mv;
        logic        dr;
        logic        rr;
        logic [2:0]  cnt;
        logic        pv;
        logic [3:0]  dest;
        logic        vc;
        logic [11:0] pd;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dp_valid_in  = 1'b0;
        dp_tag_in    = '0;
        dp_data_in   = '0;
        rsp_valid_in = 1'b0;
        rsp_data_in  = '0;
    endtask

    task automatic chk_pk(input string name, input logic pv, input logic [3:0] dest,
                          input logic vc, input logic [11:0] pd);
        chk({name, "_pk_valid"}, 32'(pk_valid_out), 32'(pv));
        chk({name, "_pk_dest"},  32'(pk_dest_out),  32'(dest));
        chk({name, "_pk_vc"},    32'(pk_vc_out),    32'(vc));
        chk({name, "_pk_data"},  32'(pk_data_out),  32'(pd));
    endtask

    initial begin
        logic [7:0] t;
        int n;

        // Basic, full, no-bypass and backpressure sequence
        vecs[0]  = '{1'b1, 8'h1B, 12'h0A5, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 4'h0, 1'b0, 12'h000};
        vecs[1]  = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b1, 12'h5A0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 4'hD, 1'b1, 12'h5A0};
        vecs[2]  = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'hD, 1'b1, 12'h5A0};
        vecs[3]  = '{1'b1, 8'h20, 12'h100, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 4'hD, 1'b1, 12'h5A0};
        vecs[4]  = '{1'b1, 8'h21, 12'h101, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 4'hD, 1'b1, 12'h5A0};
        vecs[5]  = '{1'b1, 8'h22, 12'h102, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 4'hD, 1'b1, 12'h5A0};
        vecs[6]  = '{1'b1, 8'h23, 12'h103, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 4'hD, 1'b1, 12'h5A0};
        vecs[7]  = '{1'b1, 8'h33, 12'h333, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 4'hD, 1'b1, 12'h5A0};
        vecs[8]  = '{1'b1, 8'h33, 12'h333, 1'b1, 1'b1, 12'h700, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 4'h0, 1'b0, 12'h700};
        vecs[9]  = '{1'b1, 8'h33, 12'h333, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 4'h0, 1'b0, 12'h700};
        vecs[10] = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b1, 12'h701, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 4'h0, 1'b0, 12'h700};
        vecs[11] = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b1, 12'h701, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 4'h0, 1'b1, 12'h701};
        vecs[12] = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b1, 12'h702, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 4'h0, 1'b1, 12'h701};
        vecs[13] = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b1, 12'h702, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 4'h1, 1'b0, 12'h702};
        vecs[14] = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b1, 12'h703, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 4'h1, 1'b1, 12'h703};
        vecs[15] = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b1, 12'h733, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 4'h9, 1'b1, 12'h733};
        vecs[16] = '{1'b0, 8'h00, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'h9, 1'b1, 12'h733};
        vecs[17] = '{1'b1, 8'h44, 12'h444, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'h9, 1'b1, 12'h733};

        rst          = 1'b1;
        mod_ready_in = 1'b1;
        pk_ready_in  = 1'b1;
        idle_inputs();
        #2;
        chk("rst_outstanding", 32'(outstanding_out), 32'd0);
        chk("rst_orphan",      32'(orphan_err_out),  32'd0);
        chk("rst_rsp_ready",   32'(rsp_ready_out),   32'd0);
        chk("rst_dp_ready",    32'(dp_ready_out),    32'd1);
        chk_pk("rst", 1'b0, 4'h0, 1'b0, 12'h000);
        tick();
        tick();
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            dp_valid_in  = vecs[i].dv;
            dp_tag_in    = vecs[i].tag;
            dp_data_in   = vecs[i].dd;
            mod_ready_in = vecs[i].mr;
            rsp_valid_in = vecs[i].rv;
            rsp_data_in  = vecs[i].rd;
            pk_ready_in  = vecs[i].pr;
            #1;
            chk($sformatf("v%0d_mod_valid", i), 32'(mod_valid_out), 32'(vecs[i].mv));
            chk($sformatf("v%0d_dp_ready", i),  32'(dp_ready_out),  32'(vecs[i].dr));
            chk($sformatf("v%0d_rsp_ready", i), 32'(rsp_ready_out), 32'(vecs[i].rr));
            chk($sformatf("v%0d_mod_data", i),  32'(mod_data_out),  32'(vecs[i].dd));
            tick();
            chk($sformatf("v%0d_outstanding", i), 32'(outstanding_out), 32'(vecs[i].cnt));
            chk_pk($sformatf("v%0d", i), vecs[i].pv, vecs[i].dest, vecs[i].vc, vecs[i].pd);
        end
        idle_inputs();
        mod_ready_in = 1'b1;
        pk_ready_in  = 1'b1;
        tick();

        // Order and pointer wrap with random stalls
        for (int i = 0; i < 10; i++) begin
            t = 8'(i);
            repeat ($urandom_range(0, 2)) tick();
            dp_valid_in = 1'b1;
            dp_tag_in   = t;
            dp_data_in  = 12'(i);
            #1;
            chk($sformatf("ord%0d_dp_ready", i), 32'(dp_ready_out), 32'd1);
            tick();
            dp_valid_in = 1'b0;
            chk($sformatf("ord%0d_cnt_push", i), 32'(outstanding_out), 32'd1);
            repeat ($urandom_range(0, 2)) tick();
            rsp_valid_in = 1'b1;
            rsp_data_in  = 12'h100 + 12'(i);
            #1;
            chk($sformatf("ord%0d_rsp_ready", i), 32'(rsp_ready_out), 32'd1);
            tick();
            rsp_valid_in = 1'b0;
            pk_ready_in  = 1'b0;
            chk($sformatf("ord%0d_cnt_pop", i), 32'(outstanding_out), 32'd0);
            n = $urandom_range(0, 2);
            for (int k = 0; k <= n; k++) begin
                chk_pk($sformatf("ord%0d_%0d", i, k), 1'b1, t[4:1], t[0], 12'h100 + 12'(i));
                if (k < n) tick();
            end
            pk_ready_in = 1'b1;
            tick();
            chk($sformatf("ord%0d_drained", i), 32'(pk_valid_out), 32'd0);
        end

        // Backpressure with exactly two tags pending
        dp_valid_in = 1'b1;
        dp_tag_in   = 8'h05;
        tick();
        dp_tag_in   = 8'h0A;
        tick();
        dp_valid_in  = 1'b0;
        pk_ready_in  = 1'b0;
        rsp_valid_in = 1'b1;
        rsp_data_in  = 12'h201;
        #1;
        chk("bp_first_ready", 32'(rsp_ready_out), 32'd1);
        tick();
        rsp_data_in = 12'h202;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_hold%0d_rsp_ready", k), 32'(rsp_ready_out), 32'd0);
            chk($sformatf("bp_hold%0d_cnt", k), 32'(outstanding_out), 32'd1);
            chk_pk($sformatf("bp_hold%0d", k), 1'b1, 4'h2, 1'b1, 12'h201);
            tick();
        end
        pk_ready_in = 1'b1;
        #1;
        chk("bp_release_ready", 32'(rsp_ready_out), 32'd1);
        tick();
        rsp_valid_in = 1'b0;
        chk("bp_second_cnt", 32'(outstanding_out), 32'd0);
        chk_pk("bp_second", 1'b1, 4'h5, 1'b0, 12'h202);
        tick();
        chk("bp_done_valid", 32'(pk_valid_out), 32'd0);

        // Orphan response: refused and sticky
        rsp_valid_in = 1'b1;
        rsp_data_in  = 12'hBAD;
        #1;
        chk("orph_rsp_ready", 32'(rsp_ready_out), 32'd0);
        chk("orph_not_yet",   32'(orphan_err_out), 32'd0);
        tick();
        rsp_valid_in = 1'b0;
        chk("orph_set", 32'(orphan_err_out), 32'd1);
        chk("orph_no_beat", 32'(pk_valid_out), 32'd0);
        repeat (3) tick();
        chk("orph_sticky", 32'(orphan_err_out), 32'd1);

        // Reset mid-flight: 3 tags pending and a stalled beat
        pk_ready_in = 1'b0;
        dp_valid_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dp_tag_in = 8'h0F + 8'(2 * k);
            tick();
        end
        dp_valid_in  = 1'b0;
        rsp_valid_in = 1'b1;
        rsp_data_in  = 12'h3C3;
        tick();
        rsp_valid_in = 1'b0;
        chk("mid_pre_cnt",   32'(outstanding_out), 32'd3);
        chk("mid_pre_valid", 32'(pk_valid_out),    32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_cnt",       32'(outstanding_out), 32'd0);
        chk("mid_rst_orphan",    32'(orphan_err_out),  32'd0);
        chk("mid_rst_rsp_ready", 32'(rsp_ready_out),   32'd0);
        chk("mid_rst_dp_ready",  32'(dp_ready_out),    32'd1);
        chk_pk("mid_rst", 1'b0, 4'h0, 1'b0, 12'h000);
        tick();
        rst = 1'b0;
        pk_ready_in = 1'b1;
        tick();
        dp_valid_in = 1'b1;
        dp_tag_in   = 8'h1B;
        tick();
        dp_valid_in = 1'b0;
        chk("post_rst_cnt", 32'(outstanding_out), 32'd1);
        rsp_valid_in = 1'b1;
        rsp_data_in  = 12'h0C0;
        tick();
        rsp_valid_in = 1'b0;
        chk_pk("post_rst", 1'b1, 4'hD, 1'b1, 12'h0C0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
